alu_operand_loader: RTL

Input stage directly upstream of the 3-bit ALU/7-segment top level. Captures operand A, operand B and the 4-bit ALUControl code from board switches in three button-driven steps, debouncing the raw pushbuttons. Holds all three registered and stable for the ALU, and flags when a complete operand set is present.

---
 rtl/alu_io_pkg.sv | 10 +
 rtl/button_debouncer.sv | 36 +++
 rtl/alu_operand_loader.sv | 86 ++++++++
 3 files changed

// File: rtl/alu_io_pkg.sv
// alu_io_pkg: shared state encoding and opcode width for the ALU operand loader
package alu_io_pkg;
  localparam int OPCODE_W = 4;
  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    READY   = 2'b11
  } state_t;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes, debounces and edge-detects one raw pushbutton
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic press_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_db;
  logic          r_db_d;
  logic          r_pulse;
  logic          w_diff;
  logic          w_done;
  assign w_diff = r_sync[1] ^ r_db;
  assign w_done = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_db_d  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], raw_in};
      r_cnt   <= (w_diff && !w_done) ? r_cnt + CW'(1) : '0;
      r_db    <= w_done ? ~r_db : r_db;
      r_db_d  <= r_db;
      r_pulse <= r_db & ~r_db_d;
    end
  end
  assign press_pulse = r_pulse;
endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: button-stepped capture of operands A, B and ALUControl for the ALU
module alu_operand_loader
  import alu_io_pkg::*;
#(
  parameter int N               = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        data_sw,
  input  logic [OPCODE_W-1:0] op_sw,
  input  logic                btn_next,
  input  logic                btn_clear,
  output logic [N-1:0]        A,
  output logic [N-1:0]        B,
  output logic [OPCODE_W-1:0] ALUControl,
  output logic                operands_valid,
  output logic [1:0]          step
);
  state_t              r_state, w_state_n;
  logic [N-1:0]        r_a, r_b, w_a_n, w_b_n;
  logic [OPCODE_W-1:0] r_op, w_op_n;
  logic                r_valid, w_valid_n;
  logic                w_next, w_clear;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst(rst), .raw_in(btn_next), .press_pulse(w_next)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .rst(rst), .raw_in(btn_clear), .press_pulse(w_clear)
  );
  // clear takes priority and swallows a coincident next pulse
  always_comb begin
    w_state_n = r_state;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_op_n    = r_op;
    w_valid_n = r_valid;
    if (w_clear) begin
      w_state_n = LOAD_A;
      w_a_n     = '0;
      w_b_n     = '0;
      w_op_n    = '0;
      w_valid_n = 1'b0;
    end else if (w_next) begin
      case (r_state)
        LOAD_A: begin
          w_a_n     = data_sw;
          w_state_n = LOAD_B;
        end
        LOAD_B: begin
          w_b_n     = data_sw;
          w_state_n = LOAD_OP;
        end
        LOAD_OP: begin
          w_op_n    = op_sw;
          w_valid_n = 1'b1;
          w_state_n = READY;
        end
        READY: begin
          w_valid_n = 1'b0;
          w_state_n = LOAD_A;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_op    <= w_op_n;
      r_valid <= w_valid_n;
    end
  end
  assign A              = r_a;
  assign B              = r_b;
  assign ALUControl     = r_op;
  assign operands_valid = r_valid;
  assign step           = r_state;
endmodule
